// File: rtl/blink_tick_gen.sv
// -----------------------------------------------------------------------------
// blink_tick_gen
//
// Timing source for the LED blinker stage. A raw pushbutton is synchronized,
// debounced and edge-detected. Each accepted press steps a 4-state rate FSM.
// The selected rate picks the divide ratio of a free-running counter. That
// counter produces a one-cycle tick strobe and a 50 % duty square wave.
//
// Parameters:
//   DEB_CYCLES  cycles btn_s must differ from btn_db before it is accepted (>= 2)
//   DIV0..DIV3  tick period in clk cycles for rate 0..3 (>= 2, < 2^30)
//
// Ports:
//   clk        in   single clock, posedge
//   rst_n      in   asynchronous active-low reset
//   btn        in   raw pushbutton, active-high, asynchronous, may bounce
//   en         in   divider run enable
//   tick       out  registered one-cycle strobe, once per selected period
//   half       out  registered square wave, toggles on every tick
//   rate       out  current rate index; equals the rate FSM state encoding
//   btn_press  out  registered one-cycle pulse per accepted press
// -----------------------------------------------------------------------------
module blink_tick_gen #(
  parameter int DEB_CYCLES = 1000,
  parameter int DIV0       = 50,
  parameter int DIV1       = 200,
  parameter int DIV2       = 1000,
  parameter int DIV3       = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       en,
  output logic       tick,
  output logic       half,
  output logic [1:0] rate,
  output logic       btn_press
);

  // The debounce counter only ever holds 0..DEB_CYCLES-1, so clog2 bits suffice.
  localparam int              DEB_W    = $clog2(DEB_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    RATE0 = 2'd0,
    RATE1 = 2'd1,
    RATE2 = 2'd2,
    RATE3 = 2'd3
  } rate_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer. The raw btn is not used anywhere else.
  // ---------------------------------------------------------------------------
  logic btn_meta;
  logic btn_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
    end else begin
      btn_meta <= btn;
      btn_s    <= btn_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce and press detect.
  // Any edge where btn_s agrees with btn_db restarts the count, so a bounce
  // shorter than DEB_CYCLES is never accepted. btn_press fires on the same
  // edge that btn_db is loaded with a 1; a release loads 0 and gives no pulse.
  // ---------------------------------------------------------------------------
  logic [DEB_W-1:0] deb_cnt;
  logic             btn_db;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt   <= '0;
      btn_db    <= 1'b0;
      btn_press <= 1'b0;
    end else begin
      btn_press <= 1'b0;
      if (btn_s == btn_db) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_cnt   <= '0;
        btn_db    <= btn_s;
        btn_press <= btn_s;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Rate FSM: steps RATE0 -> RATE1 -> RATE2 -> RATE3 -> RATE0 on each press.
  // The state is visible directly on the rate output.
  // ---------------------------------------------------------------------------
  rate_t state_q;
  rate_t state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RATE0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (btn_press) begin
      case (state_q)
        RATE0:   state_d = RATE1;
        RATE1:   state_d = RATE2;
        RATE2:   state_d = RATE3;
        RATE3:   state_d = RATE0;
        default: state_d = RATE0;
      endcase
    end
  end

  assign rate = state_q;

  // ---------------------------------------------------------------------------
  // Divider. The terminal count is chosen by the current state.
  // ---------------------------------------------------------------------------
  logic [29:0] div_last;

  always_comb begin
    div_last = 30'(DIV0 - 1);
    case (state_q)
      RATE0:   div_last = 30'(DIV0 - 1);
      RATE1:   div_last = 30'(DIV1 - 1);
      RATE2:   div_last = 30'(DIV2 - 1);
      RATE3:   div_last = 30'(DIV3 - 1);
      default: div_last = 30'(DIV0 - 1);
    endcase
  end

  // Priority: rate change, then enable, then terminal count.
  // The rate-change edge is the edge on which btn_press is sampled high.
  // Clearing cnt on that edge keeps cnt inside the new period, and it also
  // drops any terminal count that falls on the same edge.
  logic [29:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
      half <= 1'b0;
    end else if (btn_press) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!en) begin
      tick <= 1'b0;
    end else if (cnt == div_last) begin
      cnt  <= '0;
      tick <= 1'b1;
      half <= ~half;
    end else begin
      cnt  <= cnt + 30'd1;
      tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_blink_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_blink_tick_gen
//
// Directed bench for blink_tick_gen. It uses a short debounce window and the
// default divide ratios. Edge numbers in the expectations count posedges after
// the reset release, or after the point where the stimulus starts.
// -----------------------------------------------------------------------------
module tb_blink_tick_gen;

  localparam int DEB = 10;
  localparam int D0  = 50;
  localparam int D1  = 200;
  localparam int D2  = 1000;
  localparam int D3  = 5000;

  // ---------------- clock / reset / DUT ----------------
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn   = 1'b0;
  logic       en    = 1'b0;
  logic       tick;
  logic       half;
  logic [1:0] rate;
  logic       btn_press;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  blink_tick_gen #(
    .DEB_CYCLES (DEB),
    .DIV0       (D0),
    .DIV1       (D1),
    .DIV2       (D2),
    .DIV3       (D3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .en        (en),
    .tick      (tick),
    .half      (half),
    .rate      (rate),
    .btn_press (btn_press)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Holds reset for a few cycles, then releases it at a negedge.
  // The next posedge is edge 1.
  task automatic apply_reset();
    rst_n = 1'b0;
    btn   = 1'b0;
    en    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives a clean press: 30 cycles high, then 20 cycles low.
  // lat is the edge index of the first btn_press pulse, counted from when btn
  // goes high. npulse counts every pulse, so a pulse on release is also caught.
  task automatic do_press(output int lat, output int npulse);
    lat    = -1;
    npulse = 0;
    btn    = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (btn_press === 1'b1) begin
        npulse++;
        if (lat < 0) lat = i;
      end
    end
    btn = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (btn_press === 1'b1) npulse++;
    end
  endtask

  // Returns the number of edges until tick is seen high, or -1 on timeout.
  task automatic wait_tick(input int budget, output int got);
    got = -1;
    for (int w = 1; w <= budget; w++) begin
      @(posedge clk); #1;
      if (tick === 1'b1) begin
        got = w;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int bad_t;
    int bad_h;
    rst_n = 1'b0;
    en    = 1'b1;
    btn   = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_chk++;
    if ({tick, half, rate, btn_press} !== 5'b0) $display("FAIL reset_outputs: got %b expected 00000", {tick, half, rate, btn_press});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    bad_t = 0;
    bad_h = 0;
    // tick at edges 50/100/150; half is 1 after edges 50..99 and 0 after 100..149.
    for (int k = 1; k <= 150; k++) begin
      @(posedge clk); #1;
      if (tick !== ((k % 50) == 0)) bad_t++;
      if (half !== (((k / 50) % 2) == 1)) bad_h++;
    end
    n_chk++;
    if (bad_t != 0) $display("FAIL freerun_tick: got %0d bad cycles expected 0", bad_t);
    else n_pass++;
    n_chk++;
    if (bad_h != 0) $display("FAIL freerun_half: got %0d bad cycles expected 0", bad_h);
    else n_pass++;
    n_chk++;
    if (rate !== 2'd0) $display("FAIL freerun_rate: got %0d expected 0", rate);
    else n_pass++;
  endtask

  task automatic test_debounce();
    int bounce_press;
    int lat;
    int np;
    apply_reset();
    bounce_press = 0;
    // Toggle every 3 cycles for 42 cycles; the last phase is low.
    for (int k = 0; k < 42; k++) begin
      btn = ((k / 3) % 2) == 0;
      @(posedge clk); #1;
      if (btn_press === 1'b1) bounce_press++;
    end
    n_chk++;
    if (bounce_press != 0) $display("FAIL debounce_bounce: got %0d presses expected 0", bounce_press);
    else n_pass++;
    do_press(lat, np);
    n_chk++;
    if (lat != 2 + DEB) $display("FAIL debounce_latency: got %0d expected %0d", lat, 2 + DEB);
    else n_pass++;
    n_chk++;
    if (np != 1) $display("FAIL debounce_count: got %0d expected 1", np);
    else n_pass++;
    n_chk++;
    if (rate !== 2'd1) $display("FAIL debounce_rate: got %0d expected 1", rate);
    else n_pass++;
  endtask

  task automatic test_rate_wrap();
    logic [1:0] exp_rate [4];
    int lat;
    int np;
    int got;
    exp_rate = '{2'd1, 2'd2, 2'd3, 2'd0};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      do_press(lat, np);
      n_chk++;
      if (rate !== exp_rate[i]) $display("FAIL wrap_rate%0d: got %0d expected %0d", i, rate, exp_rate[i]);
      else n_pass++;
      n_chk++;
      if (np != 1 || lat != 2 + DEB) $display("FAIL wrap_press%0d: got %0d pulses lat %0d expected 1 lat %0d", i, np, lat, 2 + DEB);
      else n_pass++;
    end
    // The rate changed on press edge 13. do_press ran 50 edges, so the first
    // tick at rate 0 comes 13 edges later.
    wait_tick(200, got);
    n_chk++;
    if (got != D0 - (50 - (2 + DEB + 1))) $display("FAIL wrap_first_tick: got %0d expected %0d", got, D0 - (50 - (2 + DEB + 1)));
    else n_pass++;
    wait_tick(200, got);
    n_chk++;
    if (got != D0) $display("FAIL wrap_spacing: got %0d expected %0d", got, D0);
    else n_pass++;
  endtask

  task automatic test_collision();
    int early_ticks;
    apply_reset();
    early_ticks = 0;
    // btn rises before edge 38, so btn_press is high after edge 49.
    // At that point cnt is 49, which is DIV0-1.
    for (int k = 1; k <= 260; k++) begin
      btn = (k >= 38 && k < 70);
      @(posedge clk); #1;
      if (k < 250 && tick === 1'b1) early_ticks++;
      if (k == 49) begin
        n_chk++;
        if (btn_press !== 1'b1) $display("FAIL collide_press: got %b expected 1", btn_press);
        else n_pass++;
      end
      if (k == 50) begin
        n_chk++;
        if ({tick, half, rate} !== 4'b0001) $display("FAIL collide_edge: got tick/half/rate %b expected 0001", {tick, half, rate});
        else n_pass++;
      end
      if (k == 250) begin
        n_chk++;
        if (tick !== 1'b1 || half !== 1'b1) $display("FAIL collide_next_tick: got tick %b half %b expected 1 1", tick, half);
        else n_pass++;
      end
    end
    n_chk++;
    if (early_ticks != 0) $display("FAIL collide_dropped: got %0d ticks before edge 250 expected 0", early_ticks);
    else n_pass++;
  endtask

  task automatic test_enable_gate();
    int bad;
    apply_reset();
    bad = 0;
    // en is low on edges 21..50. cnt holds at 20, then reaches 49 on edge 79.
    // Ticks are expected on edges 80 and 130.
    for (int k = 1; k <= 140; k++) begin
      en = !(k >= 21 && k <= 50);
      @(posedge clk); #1;
      if (tick !== (k == 80 || k == 130)) bad++;
      if (k == 129) begin
        n_chk++;
        if (half !== 1'b1) $display("FAIL gate_half_hi: got %b expected 1", half);
        else n_pass++;
      end
    end
    en = 1'b1;
    n_chk++;
    if (bad != 0) $display("FAIL gate_ticks: got %0d bad cycles expected 0", bad);
    else n_pass++;
    n_chk++;
    if (half !== 1'b0) $display("FAIL gate_half_lo: got %b expected 0", half);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int lat;
    int np;
    int found;
    int got;
    apply_reset();
    do_press(lat, np);
    do_press(lat, np);
    n_chk++;
    if (rate !== 2'd2) $display("FAIL async_setup_rate: got %0d expected 2", rate);
    else n_pass++;
    found = 0;
    for (int w = 0; w < 3000; w++) begin
      if (half === 1'b1) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    n_chk++;
    if (found != 1) $display("FAIL async_setup_half: got half %b expected 1 within 3000 cycles", half);
    else n_pass++;
    // Pulse reset between edges. Outputs must clear before the next posedge.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({tick, half, rate, btn_press} !== 5'b0) $display("FAIL async_clear: got %b expected 00000", {tick, half, rate, btn_press});
    else n_pass++;
    #1;
    rst_n = 1'b1;
    wait_tick(100, got);
    n_chk++;
    if (got != D0) $display("FAIL async_first_tick: got %0d expected %0d", got, D0);
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_debounce();
    test_rate_wrap();
    test_collision();
    test_enable_gate();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/blink_tick_gen.md
# blink_tick_gen

Upstream timing source for the LED blinker stage. Divides the board clock into a selectable-rate one-cycle `tick` strobe and a 50 % duty `half` square wave that drives LEDs directly. Blink rate is chosen by a raw pushbutton, which the block synchronizes, debounces, edge-detects and uses to step a 4-state rate FSM. All rates are parameters: small values for simulation, board values for the FPGA.

## Interface
- `DEB_CYCLES`, default 1000. Number of consecutive cycles the synchronized button must differ from its debounced state before that state is accepted. Must be ≥ 2.
- `DIV0`, default 50. Tick period in clk cycles for rate 0.
- `DIV1`, default 200. Tick period for rate 1.
- `DIV2`, default 1000. Tick period for rate 2.
- `DIV3`, default 5000. Tick period for rate 3.
- All `DIVn` must be ≥ 2 and < 2^30.

Ports:
- `clk` in 1: the single clock; all logic is on the posedge.
- `rst_n` in 1: reset, **asynchronous, active-low**. Asserting it clears all state immediately.
- `btn` in 1: raw pushbutton, active-high, asynchronous to `clk`, may bounce.
- `en` in 1: run enable for the divider.
- `tick` out 1: registered one-cycle strobe, once per selected period.
- `half` out 1: registered square wave; toggles on every tick.
- `rate` out 2: current rate index, 0–3.
- `btn_press` out 1: registered one-cycle pulse on each accepted debounced press.

## Operation
- **Reset values:** `tick`=0, `half`=0, `rate`=0, `btn_press`=0. Internal state: divider `cnt`=0, debounce counter=0, debounced state `btn_db`=0, both synchronizer flops=0.
- **Synchronizer:** 2-flop chain on `btn` produces `btn_s`. The raw `btn` is used nowhere else.
- **Debounce:**
  - If `btn_s`==`btn_db`, clear the debounce counter.
  - Otherwise increment it. On the edge where it holds `DEB_CYCLES-1`, load `btn_db`←`btn_s` and clear the counter.
  - The counter width is derived from `DEB_CYCLES`; it never wraps.
- **Press detect:** `btn_press` is set to 1 on the same edge that `btn_db` goes 0→1, and is 0 on every other edge. Release (1→0) produces no pulse.
- **Rate FSM:** states RATE0→RATE1→RATE2→RATE3→RATE0, advancing only on `btn_press`=1. RATE3 wraps to RATE0. `rate` equals the state encoding.
- **Divider:** `DIVsel` is the `DIVn` selected by `rate`; `cnt` is 30 bits.
  - On the edge after `btn_press`=1 (the rate-change edge): `cnt`←0 and `tick`←0, whatever `en` is. `half` holds.
  - Else if `en`=0: `cnt` holds, `tick`←0, `half` holds.
  - Else if `cnt`==`DIVsel-1`: `cnt`←0, `tick`←1, `half`←~`half`.
  - Else: `cnt`←`cnt`+1, `tick`←0.
- **Priority:** rate change > en low > terminal count. A terminal count that coincides with a rate change is dropped: no tick, no toggle.
- `cnt` never exceeds `DIVsel-1` under the current rate, because any rate change clears it first.

## Timing
- Button latency: a clean `btn` 0→1 edge gives `btn_press`=1 at about 2 (sync) + `DEB_CYCLES` clock edges later. `rate` updates on the following edge.
- Tick period is exactly `DIVsel` cycles while `en`=1. `half` period is 2·`DIVsel`, 50 % duty.
- First tick after reset release with `en`=1 throughout: `tick` rises on the `DIVsel`-th posedge and is high for one cycle.
- Deasserting `en` freezes the phase; reasserting resumes counting from the held `cnt`.
- Reset asserted mid-count or mid-debounce: all outputs reach their reset values asynchronously. A bounce in progress is discarded.

## Test plan
- **Reset/free-run:** `DIV0`=50, `en`=1 after reset → `tick` pulses at posedges 50, 100, 150; `half` is 1 during cycles 50–99 and 0 during 100–149; `rate`=0.
- **Debounce:** `DEB_CYCLES`=10. `btn` bounces 1/0 every 3 cycles for 40 cycles, then holds 1 → no `btn_press` during the bouncing; exactly one `btn_press` about 12 cycles after the stable 1; `rate`=1.
- **Rate wrap:** four clean presses → `rate` reads 1, 2, 3, 0. After the 4th press, the tick spacing returns to 50.
- **Collision:** time a press so `btn_press`=1 while `cnt`=`DIV0-1` → no tick, `half` unchanged, next tick 200 cycles later (`DIV1`).
- **Enable gating:** drop `en` at `cnt`=20 for 30 cycles → no ticks during the gap; next tick 30 cycles after `en` returns.
- **Async reset mid-op:** pulse `rst_n` low between clock edges at `rate`=2, `half`=1 → all outputs are 0 before the next posedge; the first tick after release comes 50 cycles later.
